// File: rtl/spi_sram_responder.sv
// rtl/spi_sram_responder.sv - SPI mode-0 slave emulating a 23LC-class serial SRAM
//
// Purpose: decodes READ (0x03) / WRITE (0x02) commands with a 16-bit byte address
// and unlimited sequential bursts, backed by an internal 2**ADDR_BITS byte array.
// SPI pins are oversampled on clk through SYNC_STAGES synchronizer flops.
//
// Optional feature macro: SPI_SRAM_RESP_MODE_REG_EN
//   defined   : 8-bit mode register (reset 8'h40), WRMR 0x01 / RDMR 0x05 supported
//   undefined : 0x01 / 0x05 are unsupported commands (cmd_err, ignored)
//
// Ports:
//   clk       in   system clock (> 8x spi_clk)
//   rst_n     in   asynchronous active-low reset
//   spi_clk   in   SPI clock, idle low
//   spi_cs_n  in   chip select, active low
//   spi_mosi  in   master-out data, MSB first
//   spi_miso  out  slave-out data, MSB first, 0 when not shifting read data
//   busy      out  high while a framed transaction is in progress
//   cmd_err   out  one-clk pulse when an unsupported command byte completes
//
// ADDR_BITS must be in the range 9..16.

module spi_sram_responder #(
   parameter int ADDR_BITS   = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_clk,
   input  logic spi_cs_n,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic busy,
   output logic cmd_err
);

   localparam int HI_BITS = ADDR_BITS - 8;

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_RD_DATA,
      S_WR_DATA, S_MODE_RD, S_MODE_WR, S_IGNORE
   } state_t;

   state_t r_state, r_state_nxt;

   // synchronizers; cs_n chain resets low so a cs_n held low through reset
   // release never looks like a falling edge
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic                   r_sclk_prev, r_cs_prev;

   logic [6:0]           r_shift;
   logic [2:0]           r_bit_cnt;
   logic [HI_BITS-1:0]   r_addr_hi;
   logic [ADDR_BITS-1:0] r_addr;
   logic [7:0]           r_sr;
   logic                 r_miso;
   logic                 r_is_write;
   logic                 r_cmd_err;
   logic [7:0]           r_mem [0:(2**ADDR_BITS)-1];
`ifdef SPI_SRAM_RESP_MODE_REG_EN
   logic [7:0]           r_mode;
`endif

   logic                 w_sclk, w_cs, w_mosi;
   logic                 w_rise, w_fall, w_cs_fall;
   logic                 w_byte_done;
   logic [7:0]           w_byte;
   logic                 w_cmd_read, w_cmd_write, w_cmd_rdmr, w_cmd_wrmr;
   logic                 w_cmd_ok;
   logic [ADDR_BITS-1:0] w_addr_new, w_addr_inc, w_rd_idx;
   logic [7:0]           w_mem_rd;
   logic [7:0]           w_mode_val;
   logic                 w_shifting;
   logic                 w_busy, w_cmd_err_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_sclk_prev <= w_sclk;
         r_cs_prev   <= w_cs;
      end
   end

   assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
   // SPI clock edges only count while chip select is asserted
   assign w_rise    = w_sclk & ~r_sclk_prev & ~w_cs;
   assign w_fall    = ~w_sclk & r_sclk_prev & ~w_cs;
   assign w_cs_fall = ~w_cs & r_cs_prev;

   assign w_byte      = {r_shift, w_mosi};
   assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);

   assign w_cmd_read  = (w_byte == 8'h03);
   assign w_cmd_write = (w_byte == 8'h02);
`ifdef SPI_SRAM_RESP_MODE_REG_EN
   assign w_cmd_rdmr  = (w_byte == 8'h05);
   assign w_cmd_wrmr  = (w_byte == 8'h01);
   assign w_mode_val  = r_mode;
`else
   assign w_cmd_rdmr  = 1'b0;
   assign w_cmd_wrmr  = 1'b0;
   assign w_mode_val  = 8'h00;
`endif
   assign w_cmd_ok = w_cmd_read | w_cmd_write | w_cmd_rdmr | w_cmd_wrmr;

   // upper address bits beyond ADDR_BITS are dropped, so addresses alias
   assign w_addr_new = {r_addr_hi, w_byte};
   assign w_addr_inc = r_addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
   // the read port serves both the first fetch (address just completed) and
   // the burst prefetch of the following byte
   assign w_rd_idx   = (r_state == S_ADDR_LO) ? w_addr_new : w_addr_inc;
   assign w_mem_rd   = r_mem[w_rd_idx];

   assign w_shifting = (r_state == S_RD_DATA) || (r_state == S_MODE_RD);

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= r_state_nxt;
   end

   // FSM: next state
   always_comb begin
      r_state_nxt = r_state;
      if (w_cs) begin
         r_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (w_cs_fall) r_state_nxt = S_CMD;
            S_CMD: begin
               if (w_byte_done) begin
                  if (w_cmd_read || w_cmd_write) r_state_nxt = S_ADDR_HI;
                  else if (w_cmd_rdmr)           r_state_nxt = S_MODE_RD;
                  else if (w_cmd_wrmr)           r_state_nxt = S_MODE_WR;
                  else                           r_state_nxt = S_IGNORE;
               end
            end
            S_ADDR_HI: if (w_byte_done) r_state_nxt = S_ADDR_LO;
            S_ADDR_LO: if (w_byte_done) r_state_nxt = r_is_write ? S_WR_DATA : S_RD_DATA;
            S_MODE_WR: if (w_byte_done) r_state_nxt = S_IGNORE;
            default:   r_state_nxt = r_state;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      w_busy        = (r_state != S_IDLE);
      w_cmd_err_nxt = (r_state == S_CMD) && w_byte_done && !w_cmd_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt  <= 3'd0;
         r_shift    <= 7'd0;
         r_addr_hi  <= '0;
         r_addr     <= '0;
         r_sr       <= 8'h00;
         r_miso     <= 1'b0;
         r_is_write <= 1'b0;
         r_cmd_err  <= 1'b0;
`ifdef SPI_SRAM_RESP_MODE_REG_EN
         r_mode     <= 8'h40;
`endif
      end else begin
         r_cmd_err <= w_cmd_err_nxt;
         if (w_cs) begin
            r_bit_cnt <= 3'd0;
            r_miso    <= 1'b0;
         end else begin
            if (r_state == S_IDLE) begin
               r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               r_shift   <= w_byte[6:0];
            end

            if (w_byte_done) begin
               case (r_state)
                  S_CMD: begin
                     r_is_write <= w_cmd_write;
                     r_sr       <= w_mode_val;
                  end
                  S_ADDR_HI: r_addr_hi <= w_byte[HI_BITS-1:0];
                  S_ADDR_LO: begin
                     r_addr <= w_addr_new;
                     r_sr   <= w_mem_rd;
                  end
                  S_RD_DATA: begin
                     r_addr <= w_addr_inc;
                     r_sr   <= w_mem_rd;
                  end
                  S_WR_DATA: r_addr <= w_addr_inc;
                  S_MODE_RD: r_sr   <= w_mode_val;
`ifdef SPI_SRAM_RESP_MODE_REG_EN
                  S_MODE_WR: r_mode <= w_byte;
`endif
                  default: ;
               endcase
            end

            if (!w_shifting) begin
               r_miso <= 1'b0;
            end else if (w_fall) begin
               r_miso <= r_sr[7];
               r_sr   <= {r_sr[6:0], 1'b0};
            end
         end
      end
   end

   // memory contents are intentionally not reset
   always_ff @(posedge clk) begin
      if ((r_state == S_WR_DATA) && w_byte_done)
         r_mem[r_addr] <= w_byte;
   end

   assign spi_miso = r_miso;
   assign busy     = w_busy;
   assign cmd_err  = r_cmd_err;

endmodule
